// File: rtl/spi_pkg.sv
// Shared widths, idle byte and FSM state encoding for the SPI slave.
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_IDLE_BYTE = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;
endpackage

// File: rtl/spi_if.sv
// SPI pin bundle; the master drives clock, select and data out, the slave drives miso.
interface spi_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for an asynchronous input plus rise/fall detection
// against one further registered copy of the synchronized value.
module spi_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_sr;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr <= {STAGES{INIT}};
      prev    <= INIT;
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], din};
      prev    <= sync_sr[STAGES-1];
    end
  end

  assign rise = sync_sr[STAGES-1] & ~prev;
  assign fall = ~sync_sr[STAGES-1] & prev;
endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave with a one-byte transmit holding register, oversampled in
// the clk domain. Handshake: tx_load is taken only on a clk edge where tx_ready=1.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_if.slave                  spi,
  input  logic [SPI_DATA_W-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [SPI_DATA_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun,
  output logic                  frame_abort,
  output logic [0:0]            state_dbg
);
  localparam logic [0:0] IDLE  = ST_IDLE;
  localparam logic [0:0] SHIFT = ST_SHIFT;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(spi.sclk), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(spi.cs_n), .rise(cs_rise), .fall(cs_fall));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sr <= '0;
    else        mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi.mosi};
  end
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  logic [0:0]            state;
  logic [2:0]            bit_cnt;
  logic [SPI_DATA_W-1:0] rx_sh, tx_sh, hold;
  logic                  hold_full;
  logic                  byte_done;  // 8th rise seen, reload pending on next fall
  logic                  tx_empty;   // current tx byte is the idle filler
  logic                  reload;

  // The underrun pulse is raised when the filler byte actually starts shifting,
  // so the trailing fall of a frame's last byte never reports a false underrun.
  always_comb begin
    reload = 1'b0;
    if (state == IDLE && cs_fall)
      reload = 1'b1;
    else if (state == SHIFT && !cs_rise && sclk_fall && bit_cnt == 3'd0 && byte_done)
      reload = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      byte_done   <= 1'b0;
      tx_empty    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      if (tx_load && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      if (reload) begin
        byte_done <= 1'b0;
        if (hold_full) begin
          tx_sh     <= hold;
          hold_full <= 1'b0;
          tx_empty  <= 1'b0;
        end else begin
          tx_sh    <= SPI_IDLE_BYTE;
          tx_empty <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        default: begin
          if (cs_rise) begin
            state     <= IDLE;
            frame_abort <= (bit_cnt != 3'd0);
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            byte_done <= 1'b0;
            tx_empty  <= 1'b0;
          end else if (sclk_rise) begin
            rx_sh   <= {rx_sh[SPI_DATA_W-2:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd0 && tx_empty) begin
              tx_underrun <= 1'b1;
              tx_empty    <= 1'b0;
            end
            if (bit_cnt == 3'd7) begin
              rx_data   <= {rx_sh[SPI_DATA_W-2:0], mosi_s};
              rx_valid  <= 1'b1;
              byte_done <= 1'b1;
            end
          end else if (sclk_fall && bit_cnt != 3'd0) begin
            tx_sh <= {tx_sh[SPI_DATA_W-2:0], 1'b0};
          end
        end
      endcase
    end
  end

  assign tx_ready  = ~hold_full;
  assign busy      = (state == SHIFT);
  assign state_dbg = state;
  assign spi.miso  = (state == SHIFT) ? tx_sh[SPI_DATA_W-1] : 1'b0;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single-byte frames plus hand-written
// multi-byte, abort, ignored-load and mid-frame reset sequences.
module tb_spi_slave;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, tx_underrun, frame_abort;
  logic [0:0] state_dbg;

  spi_if sif ();

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi(sif.slave),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort), .state_dbg(state_dbg));

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_rxv = 0, n_und = 0, n_abt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every rx_valid pulse must match the next expected byte
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_underrun) n_und++;
      if (frame_abort) n_abt++;
      if (rx_valid) begin
        n_rxv++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rx_unexpected: got %0h expected none", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            bad++;
            $display("FAIL rx_byte: got %0h expected %0h", rx_data, e);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic cs_low();
    sif.cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    wait_clk(8);
    sif.cs_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      sif.mosi = mo[i];
      wait_clk(8);
      mi[i] = sif.miso;
      sif.sclk = 1'b1;
      wait_clk(8);
      sif.sclk = 1'b0;
    end
  endtask

  typedef struct {
    logic       load;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] mi, mi2;
    int rxv0, und0, abt0;

    vecs[0] = '{load: 1'b1, tx: 8'hA5, mo: 8'h3C, exp_mi: 8'hA5, exp_rx: 8'h3C};
    vecs[1] = '{load: 1'b0, tx: 8'h00, mo: 8'h55, exp_mi: 8'hFF, exp_rx: 8'h55};
    vecs[2] = '{load: 1'b1, tx: 8'h00, mo: 8'hFF, exp_mi: 8'h00, exp_rx: 8'hFF};
    vecs[3] = '{load: 1'b1, tx: 8'hC3, mo: 8'h81, exp_mi: 8'hC3, exp_rx: 8'h81};

    rst_n = 1'b0; tx_data = 8'h00; tx_load = 1'b0;
    sif.sclk = 1'b0; sif.cs_n = 1'b1; sif.mosi = 1'b0;
    wait_clk(3);
    chk("rst_miso", 32'(sif.miso), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clk(3);

    // single-byte frames
    for (int v = 0; v < 4; v++) begin
      rxv0 = n_rxv; und0 = n_und;
      if (vecs[v].load) begin
        load_byte(vecs[v].tx);
        chk("tx_ready_after_load", 32'(tx_ready), 32'd0);
      end
      exp_q.push_back(vecs[v].exp_rx);
      cs_low();
      chk("busy_in_frame", 32'(busy), 32'd1);
      chk("state_shift", 32'(state_dbg), 32'd1);
      spi_bits(vecs[v].mo, 8, mi);
      cs_high();
      chk("vec_miso_byte", 32'(mi), 32'(vecs[v].exp_mi));
      chk("vec_rx_data", 32'(rx_data), 32'(vecs[v].exp_rx));
      chk("vec_rx_valid_cnt", 32'(n_rxv - rxv0), 32'd1);
      chk("vec_underrun_cnt", 32'(n_und - und0), vecs[v].load ? 32'd0 : 32'd1);
      chk("vec_tx_ready", 32'(tx_ready), 32'd1);
      chk("vec_busy_idle", 32'(busy), 32'd0);
    end

    // two bytes in one frame, second byte loaded during the first
    rxv0 = n_rxv; und0 = n_und;
    load_byte(8'h11);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    cs_low();
    fork
      spi_bits(8'h01, 8, mi);
      begin wait_clk(30); load_byte(8'h22); end
    join
    spi_bits(8'h80, 8, mi2);
    cs_high();
    chk("two_byte_mi0", 32'(mi), 32'h11);
    chk("two_byte_mi1", 32'(mi2), 32'h22);
    chk("two_byte_rxv", 32'(n_rxv - rxv0), 32'd2);
    chk("two_byte_und", 32'(n_und - und0), 32'd0);

    // abort after 5 bits, then a clean frame
    rxv0 = n_rxv; abt0 = n_abt;
    cs_low();
    spi_bits(8'hAA, 5, mi);
    cs_high();
    chk("abort_rxv", 32'(n_rxv - rxv0), 32'd0);
    chk("abort_pulse", 32'(n_abt - abt0), 32'd1);
    load_byte(8'h5A);
    exp_q.push_back(8'hC3);
    cs_low();
    spi_bits(8'hC3, 8, mi);
    cs_high();
    chk("after_abort_mi", 32'(mi), 32'h5A);
    chk("after_abort_rx", 32'(rx_data), 32'hC3);
    chk("no_abort_at_zero", 32'(n_abt - abt0), 32'd1);

    // load while holding register full is ignored
    load_byte(8'h99);
    chk("hold_full_ready", 32'(tx_ready), 32'd0);
    load_byte(8'h77);
    exp_q.push_back(8'h12);
    cs_low();
    spi_bits(8'h12, 8, mi);
    cs_high();
    chk("ignored_load_mi", 32'(mi), 32'h99);
    chk("ignored_load_ready", 32'(tx_ready), 32'd1);
    exp_q.push_back(8'h34);
    cs_low();
    spi_bits(8'h34, 8, mi);
    cs_high();
    chk("ignored_load_never_sent", 32'(mi), 32'hFF);

    // reset after 3 bits
    rxv0 = n_rxv; abt0 = n_abt;
    load_byte(8'hE7);
    cs_low();
    spi_bits(8'hB6, 3, mi);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_miso", 32'(sif.miso), 32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("mid_rst_rx_data", 32'(rx_data), 32'h00);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_underrun", 32'(tx_underrun), 32'd0);
    chk("mid_rst_abort", 32'(frame_abort), 32'd0);
    wait_clk(3);
    sif.cs_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(10);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_no_pulses", 32'(n_rxv - rxv0 + n_abt - abt0), 32'd0);
    load_byte(8'h0F);
    exp_q.push_back(8'hF0);
    cs_low();
    spi_bits(8'hF0, 8, mi);
    cs_high();
    chk("post_rst_mi", 32'(mi), 32'h0F);
    chk("post_rst_rx", 32'(rx_data), 32'hF0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
